// File: rtl/delay_vec.sv
// delay_vec: DEPTH-tap shift register of ADC samples with a registered fill flag
module delay_vec #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] ADC_IN,
  output logic [WIDTH-1:0] DelayVec [0:DEPTH-1],
  output logic             Full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [CW-1:0] fill, fill_nxt;
  always_comb fill_nxt = (fill == FULL_CNT) ? fill : fill + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) DelayVec[i] <= '0;
      fill <= '0;
      Full <= 1'b0;
    end else begin
      DelayVec[0] <= ADC_IN;
      for (int i = 1; i < DEPTH; i++) DelayVec[i] <= DelayVec[i-1];
      fill <= fill_nxt;
      // Full is derived from the next count so it rises on the DEPTH-th edge
      Full <= (fill_nxt == FULL_CNT);
    end
endmodule

// File: tb/tb_delay_vec.sv
// tb_delay_vec: random and directed checks of delay_vec against a sample-history model
module tb_delay_vec;
  localparam int W = 14, D = 100;
  logic clk = 1'b0, reset_n = 1'b0, full;
  logic [W-1:0] adc_in = '0;
  logic [W-1:0] dv [0:D-1];
  int checks = 0, errors = 0, edges = 0;
  logic [W-1:0] hist [$];
  delay_vec #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset_n(reset_n), .ADC_IN(adc_in),
    .DelayVec(dv), .Full(full));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] tap(input int k);
    return (k < hist.size()) ? hist[k] : '0;
  endfunction
  task automatic check_all(input string tag);
    for (int k = 0; k < D; k++) check($sformatf("%s_tap%0d", tag, k), 32'(dv[k]), 32'(tap(k)));
    check({tag, "_full"}, 32'(full), 32'(edges >= D));
  endtask
  task automatic step(input logic [W-1:0] v);
    adc_in = v;
    @(posedge clk);
    hist.push_front(v);
    if (hist.size() > D) void'(hist.pop_back());
    edges++;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    hist.delete();
    edges = 0;
    #1 check_all("rst");
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    logic [W-1:0] s26 [5] = '{8054, 8062, 8051, 8042, 8070};
    logic [W-1:0] s27 [23] = '{8054, 8062, 8051, 8042, 8070, 8053, 8050, 8055, 8072, 8062, 8050,
      8072, 8073, 8056, 8051, 8061, 8063, 8078, 8079, 8067, 11054, 13843, 11721};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(s26[i]);
      check_all($sformatf("seq5_e%0d", i + 1));
    end
    for (int k = 0; k < 5; k++) check($sformatf("seq5_dir%0d", k), 32'(dv[k]), 32'(s26[4-k]));
    check("seq5_tap5", 32'(dv[5]), 0);
    check("seq5_full", 32'(full), 0);
    do_reset();
    for (int i = 0; i < 23; i++) step(s27[i]);
    check_all("seq23");
    check("seq23_t0", 32'(dv[0]), 11721);
    check("seq23_t1", 32'(dv[1]), 13843);
    check("seq23_t2", 32'(dv[2]), 11054);
    check("seq23_t22", 32'(dv[22]), 8054);
    check("seq23_t23", 32'(dv[23]), 0);
    do_reset();
    step(14'h3FFF);
    check_all("imp_e1");
    for (int e = 2; e <= 102; e++) begin
      step('0);
      if (e <= D) check($sformatf("imp_at%0d", e - 1), 32'(dv[e-1]), 32'h3FFF);
      check_all($sformatf("imp_e%0d", e));
    end
    do_reset();
    for (int i = 0; i < 120; i++) begin
      step(W'(i));
      check($sformatf("ramp_full_e%0d", i + 1), 32'(full), 32'(i + 1 >= D));
      if (i >= 99) check($sformatf("ramp_t99_e%0d", i + 1), 32'(dv[99]), 32'(i - 99));
      if (i == 0 || i == 98 || i == 99 || i == 119) check_all($sformatf("ramp_e%0d", i + 1));
    end
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(W'($urandom));
      check_all($sformatf("rnd_a%0d", i));
    end
    #2 reset_n = 1'b0;
    hist.delete();
    edges = 0;
    #1 check_all("async_rst");
    #1 reset_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step(W'($urandom));
      check_all($sformatf("rnd_b%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
